reset_sequencer: RTL

Parametrised multi-domain reset generator that supersedes the single-output synchronizer. It takes the board-level synchronous reset plus a software reset request. It drives NUM_CH reset channels, each with active-high and active-low outputs, and releases them in ascending index order. A programmable hold time and inter-channel gap separate the releases, and release can optionally wait for each domain's ready acknowledge. It sits at the top of the clock domain, after the clock is stable, and feeds every sub-block reset in that domain.

---
 rtl/reset_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: holds every channel in reset after the cause clears,
// then releases channels in ascending order with a fixed gap and optional ready handshake.
module reset_sequencer #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STEP_CYCLES = 8,
    parameter int unsigned ACK_EN      = 0,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sw_rst_req,
    input  logic [NUM_CH-1:0] ch_ready,
    output logic [NUM_CH-1:0] reset,
    output logic [NUM_CH-1:0] resetn_out,
    output logic              done,
    output logic              busy,
    output logic [NUM_CH-1:0] timeout_err
);

    localparam int unsigned MaxHs  = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int unsigned MaxCnt = (MaxHs > ACK_TIMEOUT) ? MaxHs : ACK_TIMEOUT;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam int unsigned IdxW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CH - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [2:0] {
        StAssert,
        StHold,
        StWaitAck,
        StGap,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic [NUM_CH-1:0] terr_q, terr_d;
    logic              done_q, done_d;
    logic              rel;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        terr_d  = terr_q;
        done_d  = done_q;
        rel     = 1'b0;

        unique case (state_q)
            StAssert, StHold, StGap: begin
                // cnt reaching 1 marks the release edge; it never decrements below that
                if (cnt_q == CntOne) begin
                    rel = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                    if (state_q == StAssert) state_d = StHold;
                end
            end
            StWaitAck: begin
                if (ch_ready[idx_q] || (cnt_q == CntOne)) begin
                    if (!ch_ready[idx_q]) terr_d[idx_q] = 1'b1;
                    if (idx_q == LastIdx) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        cnt_d   = CntW'(STEP_CYCLES);
                        state_d = StGap;
                    end
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StDone: begin
            end
            default: state_d = StAssert;
        endcase

        if (rel) begin
            rst_d[idx_q] = 1'b0;
            if (ACK_EN != 0) begin
                cnt_d   = CntW'(ACK_TIMEOUT);
                state_d = StWaitAck;
            end else if (idx_q == LastIdx) begin
                done_d  = 1'b1;
                state_d = StDone;
            end else begin
                idx_d   = idx_q + IdxW'(1);
                cnt_d   = CntW'(STEP_CYCLES);
                state_d = StGap;
            end
        end

        // Software restart keeps the sticky timeout flags
        if (sw_rst_req) begin
            state_d = StAssert;
            cnt_d   = CntW'(HOLD_CYCLES);
            idx_d   = '0;
            rst_d   = '1;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StAssert;
            cnt_q   <= CntW'(HOLD_CYCLES);
            idx_q   <= '0;
            rst_q   <= '1;
            terr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            terr_q  <= terr_d;
            done_q  <= done_d;
        end
    end

    assign reset       = rst_q;
    assign resetn_out  = ~rst_q;
    assign done        = done_q;
    assign busy        = ~done_q;
    assign timeout_err = terr_q;

endmodule
